// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding, parity
// mode constants and small helpers used by the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_state_e;

  localparam logic PARITY_MODE_EVEN = 1'b0;
  localparam logic PARITY_MODE_ODD  = 1'b1;

  localparam int MAX_DATA_BITS = 9;

  // Counter value at the centre of the start bit.
  function automatic int mid_count(input int clks_per_bit);
    return (clks_per_bit - 32'sd1) / 32'sd2;
  endfunction

  // Unused upper data bits are zero, so they do not disturb the XOR.
  function automatic logic parity_mismatch(input logic [MAX_DATA_BITS-1:0] data,
                                           input logic                     par_bit,
                                           input logic                     odd);
    return ((^data) ^ par_bit) != odd;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous, idle-high pin input.
module uart_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Capture the pin twice; both stages reset to the idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: mid-bit sampling FSM, parity/stop checks and a
// one-entry holding register with valid/ready handshake and overrun pulse.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 521,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 rx_clk,
  input  logic                 rst_n,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 32'sd1);

  localparam logic [CW-1:0] MID_CNT   = CW'(mid_count(CLKS_PER_BIT));
  localparam logic [CW-1:0] LAST_CNT  = CW'(CLKS_PER_BIT - 32'sd1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(32'd1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 32'sd1);
  localparam logic [IW-1:0] IDX_ONE   = IW'(32'd1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 32'sd1);
  localparam logic          PAR_MODE  = (PARITY_ODD != 32'sd0) ? PARITY_MODE_ODD
                                                                : PARITY_MODE_EVEN;

  logic rxs_s;

  uart_state_e          state_r,    state_nx;
  logic [CW-1:0]        cnt_r,      cnt_nx;
  logic [IW-1:0]        idx_r,      idx_nx;
  logic                 stop_idx_r, stop_idx_nx;
  logic [DATA_BITS-1:0] shift_r,    shift_nx;
  logic                 perr_r,     perr_nx;
  logic                 ferr_r,     ferr_nx;
  logic                 done_r,     done_nx;

  logic [DATA_BITS-1:0] data_r;
  logic                 valid_r;
  logic                 perr_out_r;
  logic                 ferr_out_r;
  logic                 ovr_r;
  logic                 busy_r;

  uart_sync2 u_sync (
    .clk   (rx_clk),
    .rst_n (rst_n),
    .d     (rx_in),
    .q     (rxs_s)
  );

  // Next-state, counter, shifter and per-frame error flag logic.
  always_comb begin
    state_nx    = state_r;
    cnt_nx      = cnt_r;
    idx_nx      = idx_r;
    stop_idx_nx = stop_idx_r;
    shift_nx    = shift_r;
    perr_nx     = perr_r;
    ferr_nx     = ferr_r;
    done_nx     = 1'b0;

    case (state_r)
      IDLE: begin
        cnt_nx      = '0;
        idx_nx      = '0;
        stop_idx_nx = 1'b0;
        if (!rxs_s) begin
          state_nx = START;
        end else begin
          state_nx = IDLE;
        end
      end

      START: begin
        if (cnt_r == MID_CNT) begin
          cnt_nx = '0;
          if (!rxs_s) begin
            state_nx = DATA;
            perr_nx  = 1'b0;
            ferr_nx  = 1'b0;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          cnt_nx = cnt_r + CNT_ONE;
        end
      end

      DATA: begin
        if (cnt_r == LAST_CNT) begin
          cnt_nx = '0;
          for (int i = 0; i < DATA_BITS; i++) begin
            if (idx_r == IW'(i)) begin
              shift_nx[i] = rxs_s;
            end else begin
              shift_nx[i] = shift_r[i];
            end
          end
          if (idx_r == LAST_IDX) begin
            idx_nx   = '0;
            state_nx = (PARITY_EN != 32'sd0) ? PARITY : STOP;
          end else begin
            idx_nx = idx_r + IDX_ONE;
          end
        end else begin
          cnt_nx = cnt_r + CNT_ONE;
        end
      end

      PARITY: begin
        if (cnt_r == LAST_CNT) begin
          cnt_nx   = '0;
          perr_nx  = parity_mismatch(MAX_DATA_BITS'(shift_r), rxs_s, PAR_MODE);
          state_nx = STOP;
        end else begin
          cnt_nx = cnt_r + CNT_ONE;
        end
      end

      STOP: begin
        if (cnt_r == LAST_CNT) begin
          cnt_nx  = '0;
          ferr_nx = ferr_r | ~rxs_s;
          if (stop_idx_r == STOP_LAST) begin
            done_nx     = 1'b1;
            stop_idx_nx = 1'b0;
            // A line still low at mid-stop is a break: wait for it to release.
            state_nx    = rxs_s ? IDLE : BREAK;
          end else begin
            stop_idx_nx = 1'b1;
          end
        end else begin
          cnt_nx = cnt_r + CNT_ONE;
        end
      end

      BREAK: begin
        cnt_nx = '0;
        if (rxs_s) begin
          state_nx = IDLE;
        end else begin
          state_nx = BREAK;
        end
      end

      default: begin
        state_nx    = IDLE;
        cnt_nx      = '0;
        idx_nx      = '0;
        stop_idx_nx = 1'b0;
      end
    endcase
  end

  // Receive FSM state, counters, shifter and frame-complete strobe.
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      idx_r      <= '0;
      stop_idx_r <= 1'b0;
      shift_r    <= '0;
      perr_r     <= 1'b0;
      ferr_r     <= 1'b0;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nx;
      cnt_r      <= cnt_nx;
      idx_r      <= idx_nx;
      stop_idx_r <= stop_idx_nx;
      shift_r    <= shift_nx;
      perr_r     <= perr_nx;
      ferr_r     <= ferr_nx;
      done_r     <= done_nx;
      busy_r     <= (state_nx != IDLE);
    end
  end

  // Holding register: load on completion if empty or being drained, else flag overrun.
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r     <= '0;
      valid_r    <= 1'b0;
      perr_out_r <= 1'b0;
      ferr_out_r <= 1'b0;
      ovr_r      <= 1'b0;
    end else begin
      ovr_r <= 1'b0;
      if (done_r) begin
        if (!valid_r || rx_ready) begin
          data_r     <= shift_r;
          perr_out_r <= perr_r;
          ferr_out_r <= ferr_r;
          valid_r    <= 1'b1;
        end else begin
          ovr_r <= 1'b1;
        end
      end else if (valid_r && rx_ready) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end
    end
  end

  assign rx_data     = data_r;
  assign rx_valid    = valid_r;
  assign parity_err  = perr_out_r;
  assign frame_err   = ferr_out_r;
  assign overrun_err = ovr_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: three instances (8N1, 7E1, 8N2) share one clock.
module tb_uart_rx_cfg;

  localparam int CPB = 16;

  logic rx_clk = 1'b0;
  always #5 rx_clk = ~rx_clk;

  logic       rst_n;
  logic [2:0] line;
  logic [2:0] rdy;
  logic [2:0] vld, perr, ferr, ovr, busy;
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic [7:0] data_c;
  logic [8:0] dw [3];

  assign dw[0] = {1'b0, data_a};
  assign dw[1] = {2'b00, data_b};
  assign dw[2] = {1'b0, data_c};

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
    .rx_clk(rx_clk), .rst_n(rst_n), .rx_in(line[0]), .rx_data(data_a), .rx_valid(vld[0]),
    .rx_ready(rdy[0]), .parity_err(perr[0]), .frame_err(ferr[0]), .overrun_err(ovr[0]), .busy(busy[0]));

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_7e1 (
    .rx_clk(rx_clk), .rst_n(rst_n), .rx_in(line[1]), .rx_data(data_b), .rx_valid(vld[1]),
    .rx_ready(rdy[1]), .parity_err(perr[1]), .frame_err(ferr[1]), .overrun_err(ovr[1]), .busy(busy[1]));

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_8n2 (
    .rx_clk(rx_clk), .rst_n(rst_n), .rx_in(line[2]), .rx_data(data_c), .rx_valid(vld[2]),
    .rx_ready(rdy[2]), .parity_err(perr[2]), .frame_err(ferr[2]), .overrun_err(ovr[2]), .busy(busy[2]));

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rise_cyc_a = 0;
  logic vld_a_d = 1'b0;
  int ovr_cnt [3] = '{0, 0, 0};

  // Expected words: {parity_err, frame_err, data[8:0]}
  logic [10:0] q0 [$];
  logic [10:0] q1 [$];
  logic [10:0] q2 [$];

  always @(posedge rx_clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [10:0] pack(input logic [8:0] d, input logic p, input logic f);
    return {p, f, d};
  endfunction

  // Monitor: pop and compare on every accepted word, count overrun pulses.
  always @(negedge rx_clk) begin : mon
    logic [10:0] got;
    logic [10:0] exp;
    bit have;
    if (rst_n) begin
      for (int ch = 0; ch < 3; ch++) begin
        if (ovr[ch]) ovr_cnt[ch]++;
        if (vld[ch] && rdy[ch]) begin
          got  = {perr[ch], ferr[ch], dw[ch]};
          have = 1'b0;
          exp  = '0;
          case (ch)
            0: if (q0.size() > 0) begin exp = q0.pop_front(); have = 1'b1; end
            1: if (q1.size() > 0) begin exp = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin exp = q2.pop_front(); have = 1'b1; end
          endcase
          if (have) begin
            check($sformatf("ch%0d word", ch), 32'(got), 32'(exp));
          end else begin
            n_vec++;
            n_err++;
            $display("FAIL ch%0d unexpected word: got %h, expected none", ch, got);
          end
        end
      end
      if (vld[0] && !vld_a_d) rise_cyc_a = cyc;
      vld_a_d = vld[0];
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge rx_clk);
    #1;
  endtask

  task automatic drive_bit(input int ch, input logic v);
    line[ch] = v;
    wait_cycles(CPB);
  endtask

  task automatic send_frame(input int ch, input logic [8:0] d, input int nbits,
                            input bit par_en, input logic par_bit,
                            input int nstop, input logic stop2);
    start_cyc = cyc;
    drive_bit(ch, 1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(ch, d[i]);
    if (par_en) drive_bit(ch, par_bit);
    drive_bit(ch, 1'b1);
    if (nstop == 2) drive_bit(ch, stop2);
  endtask

  task automatic check_reset(input string tag);
    for (int ch = 0; ch < 3; ch++) begin
      check($sformatf("%s ch%0d rx_valid", tag, ch), 32'(vld[ch]), 32'd0);
      check($sformatf("%s ch%0d rx_data", tag, ch), 32'(dw[ch]), 32'd0);
      check($sformatf("%s ch%0d parity_err", tag, ch), 32'(perr[ch]), 32'd0);
      check($sformatf("%s ch%0d frame_err", tag, ch), 32'(ferr[ch]), 32'd0);
      check($sformatf("%s ch%0d overrun_err", tag, ch), 32'(ovr[ch]), 32'd0);
      check($sformatf("%s ch%0d busy", tag, ch), 32'(busy[ch]), 32'd0);
    end
  endtask

  initial begin
    int ovr_base;
    rst_n = 1'b0;
    line  = 3'b111;
    rdy   = 3'b111;
    wait_cycles(3);
    check_reset("reset");
    rst_n = 1'b1;
    wait_cycles(4);

    // 8N1 0xA5, ready held high; latency from pin start edge is 156 cycles
    q0.push_back(pack(9'h0A5, 1'b0, 1'b0));
    send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1);
    check("8n1 valid latency", 32'(rise_cyc_a - start_cyc), 32'd156);
    wait_cycles(2);
    check("8n1 valid single cycle", 32'(vld[0]), 32'd0);

    // 7E1: 0x35 has four ones -> even parity bit 0; 0x7F has seven -> 1
    q1.push_back(pack(9'h035, 1'b0, 1'b0));
    send_frame(1, 9'h035, 7, 1'b1, 1'b0, 1, 1'b1);
    q1.push_back(pack(9'h035, 1'b1, 1'b0));
    send_frame(1, 9'h035, 7, 1'b1, 1'b1, 1, 1'b1);
    q1.push_back(pack(9'h07F, 1'b0, 1'b0));
    send_frame(1, 9'h07F, 7, 1'b1, 1'b1, 1, 1'b1);
    wait_cycles(4);

    // 8N2: second stop bit low -> frame_err, then line held low (break)
    q2.push_back(pack(9'h03C, 1'b0, 1'b1));
    send_frame(2, 9'h03C, 8, 1'b0, 1'b0, 2, 1'b0);
    wait_cycles(24);
    check("break busy", 32'(busy[2]), 32'd1);
    wait_cycles(24);
    line[2] = 1'b1;
    wait_cycles(6);
    check("break release idle", 32'(busy[2]), 32'd0);
    q2.push_back(pack(9'h0C3, 1'b0, 1'b0));
    send_frame(2, 9'h0C3, 8, 1'b0, 1'b0, 2, 1'b1);
    wait_cycles(4);

    // Overrun: consumer stalled, second word dropped
    rdy[0] = 1'b0;
    ovr_base = ovr_cnt[0];
    q0.push_back(pack(9'h011, 1'b0, 1'b0));
    send_frame(0, 9'h011, 8, 1'b0, 1'b0, 1, 1'b1);
    send_frame(0, 9'h022, 8, 1'b0, 1'b0, 1, 1'b1);
    check("overrun pulse count", 32'(ovr_cnt[0] - ovr_base), 32'd1);
    check("overrun held valid", 32'(vld[0]), 32'd1);
    check("overrun held data", 32'(data_a), 32'h11);
    wait_cycles(8);
    check("overrun pulse width", 32'(ovr_cnt[0] - ovr_base), 32'd1);
    rdy[0] = 1'b1;
    wait_cycles(2);
    check("overrun drain", 32'(vld[0]), 32'd0);

    // Start-bit glitch of 5 cycles
    ovr_base = ovr_cnt[0];
    line[0] = 1'b0;
    wait_cycles(5);
    line[0] = 1'b1;
    check("glitch busy", 32'(busy[0]), 32'd1);
    wait_cycles(20);
    check("glitch idle", 32'(busy[0]), 32'd0);
    check("glitch no overrun", 32'(ovr_cnt[0] - ovr_base), 32'd0);

    // Reset during bit 4, then a clean frame
    drive_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(0, 1'b1);
    line[0] = 1'b1;
    wait_cycles(8);
    check("pre-reset busy", 32'(busy[0]), 32'd1);
    rst_n = 1'b0;
    #2;
    check_reset("mid-frame reset");
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(3);
    q0.push_back(pack(9'h05A, 1'b0, 1'b0));
    send_frame(0, 9'h05A, 8, 1'b0, 1'b0, 1, 1'b1);
    wait_cycles(10);

    check("ch0 words outstanding", 32'(q0.size()), 32'd0);
    check("ch1 words outstanding", 32'(q1.size()), 32'd0);
    check("ch2 words outstanding", 32'(q2.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
- Configurable UART receiver: line synchroniser, mid-bit sampling FSM, parity/stop checking and a one-entry output holding register with valid/ready handshake.
- Generalises the fixed 8N1 receiver to 5–9 data bits, optional even/odd parity and 1 or 2 stop bits.
- Adds per-frame error flags and overrun detection.
- Sits between the serial pin and a byte consumer (FIFO or register block); pairs with the existing transmitter.

Parameters:
- CLKS_PER_BIT, 521, rx_clk cycles per bit (rx_clk freq / baud); must be >= 4.
- DATA_BITS, 8, data bits per frame, legal 5..9, sent LSB first.
- PARITY_EN, 0, 1 = a parity bit follows the data bits.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0.
- STOP_BITS, 1, stop bits per frame, 1 or 2.

Ports:
- rx_clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rx_in  in  1  asynchronous serial line, idle high.
- rx_data  out  DATA_BITS  received word, valid while rx_valid = 1.
- rx_valid  out  1  holding register full.
- rx_ready  in  1  consumer accepts the word when rx_valid & rx_ready on an rx_clk edge.
- parity_err  out  1  parity mismatch for the held word; qualified by rx_valid.
- frame_err  out  1  a stop bit was sampled 0 for the held word; qualified by rx_valid.
- overrun_err  out  1  one-cycle pulse: a completed frame was dropped.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Clock and reset: single clock rx_clk. Reset is asynchronous, active-low (rst_n).
- Reset values: rx_data = 0, rx_valid = 0, parity_err = 0, frame_err = 0, overrun_err = 0, busy = 0. Both synchroniser flops reset to 1. FSM = IDLE, bit counter = 0, bit index = 0, shift register = 0.
- Synchroniser: two flops on rx_in; all logic uses the second flop (rxs). The first sample lags the pin by 2 cycles.
- Counter: width $clog2(CLKS_PER_BIT); wraps to 0 on every sample point. Bit index: width $clog2(DATA_BITS+1).
- IDLE:
  - rxs = 0 -> START with counter cleared.
  - rxs = 1 -> stay in IDLE.
- START:
  - At counter == (CLKS_PER_BIT-1)/2, rxs = 0 -> DATA.
  - At the same point, rxs = 1 -> IDLE (glitch rejected, nothing reported).
- DATA: sample when the counter reaches CLKS_PER_BIT-1, i.e. mid-bit.
  - Shift into shift[index] and increment the index.
  - After DATA_BITS samples -> PARITY if PARITY_EN, else STOP.
- PARITY:
  - Sample one bit.
  - perr = (XOR of the data bits ^ sampled bit) != PARITY_ODD.
- STOP:
  - Sample STOP_BITS bits at mid-bit.
  - ferr = any stop sample was 0.
  - After the last stop sample, next state:
    - IDLE if rxs = 1.
    - BREAK if rxs = 0.
- BREAK: wait until rxs = 1, then IDLE. A new start bit is not accepted while in BREAK.
- Completion (the cycle after the last stop sample):
  - If the holding register is empty, or rx_ready = 1 in the same cycle: load rx_data, parity_err and frame_err, and set rx_valid.
  - Otherwise keep the old word and pulse overrun_err for 1 cycle.
- Handshake:
  - rx_valid falls on the edge where rx_ready = 1, unless a new word loads in that same edge; in that case rx_valid stays 1 with the new contents.
  - rx_data is stable while rx_valid = 1.
- Frames with errors are still delivered; error flags travel with the word.
- Latency: rx_valid rises 1 cycle after the mid-point sample of the last stop bit. Returning to IDLE at mid-stop permits back-to-back frames.
- Reset asserted mid-frame: immediate return to reset values; the partial word is discarded.

Decomposition:
- Shared package uart_pkg:
  - State encoding constants IDLE, START, DATA, PARITY, STOP, BREAK (3-bit).
  - Parity mode constants.
  - A function computing the mid-bit count from CLKS_PER_BIT.
- One natural sub-module: uart_sync2, the 2-flop synchroniser with reset value 1, reused by other pin inputs.
- The FSM, shifter and holding register stay in uart_rx_cfg.

Test Plan (CLKS_PER_BIT = 16 unless noted):
- 8N1, send 0xA5, rx_ready = 1 -> rx_valid high for 1 cycle, rx_data = 0xA5, both error flags 0, rx_valid 1 cycle after stop-bit mid-sample.
- DATA_BITS = 7, PARITY_EN = 1, PARITY_ODD = 0; send 0x35 with a correct parity bit, then with a flipped parity bit -> rx_data = 0x35 both times; parity_err = 0, then 1.
- STOP_BITS = 2, send 0x3C with the second stop bit driven 0 -> frame_err = 1 with rx_data = 0x3C. Hold the line low 3 bit times -> busy = 1, no new frame until the line returns high.
- rx_ready = 0, send 0x11 then 0x22 -> rx_data stays 0x11, overrun_err pulses once at completion of 0x22. Then raise rx_ready -> 0x11 accepted, rx_valid falls.
- 5-cycle low glitch on rx_in while idle -> FSM returns to IDLE, no rx_valid, no error pulse.
- Assert rst_n = 0 during bit 4 of a frame, release, send 0x5A -> only 0x5A is reported; all outputs at reset values during reset.
